mvu_serializer: RTL

- Output-side counterpart of the matrix-vector unit. The unit consumes 2-bit-per-element activation planes on D and produces n wide w-bit accumulator words on O.
- This block takes one vector of n accumulator words and requantizes each word: arithmetic right shift, then signed saturation to p bits.
- It then emits the result as p/2 successive 2-bit planes, most-significant pair first, in the D format the unit consumes. This lets one layer's results feed the next layer.
- Valid/ready handshakes on both sides. It provides first/last plane flags, which downstream logic uses to drive the unit's clr and sh.

---
 rtl/mvu_serializer_if.sv | 28 ++
 rtl/mvu_serializer.sv | 93 +++++++++
 2 files changed

// File: rtl/mvu_serializer_if.sv
// Handshake bundle between the accumulator side (O, shr) and the plane side (D, first, last).
// master drives vectors in and accepts planes; slave is the serializer.
interface mvu_serializer_if #(
    parameter int unsigned n = 64,
    parameter int unsigned w = 32
) ();
    localparam int unsigned b = $clog2(w);

    logic [b-1:0]   shr;
    logic           in_valid;
    logic           in_ready;
    logic [n*w-1:0] O;
    logic           out_valid;
    logic           out_ready;
    logic [2*n-1:0] D;
    logic           first;
    logic           last;

    modport master (
        output shr, in_valid, O, out_ready,
        input  in_ready, out_valid, D, first, last
    );

    modport slave (
        input  shr, in_valid, O, out_ready,
        output in_ready, out_valid, D, first, last
    );
endinterface

// File: rtl/mvu_serializer.sv
// Requantizes n accumulator words (arithmetic shift + signed saturation to p bits) and emits
// them as p/2 two-bit planes, most-significant pair first.
module mvu_serializer #(
    parameter int unsigned n = 64,
    parameter int unsigned w = 32,
    parameter int unsigned p = 8
) (
    input logic clk,
    input logic clr,
    mvu_serializer_if.slave bus
);
    localparam int unsigned b  = $clog2(w);
    localparam int unsigned cw = (p > 2) ? $clog2(p / 2) : 1;
    localparam logic [cw-1:0] cnt_top = cw'(p / 2 - 1);
    localparam logic signed [w-1:0] qmax = {{(w - p + 1){1'b0}}, {(p - 1){1'b1}}};
    localparam logic signed [w-1:0] qmin = {{(w - p + 1){1'b1}}, {(p - 1){1'b0}}};

    typedef enum logic {st_idle, st_send} state_e;

    state_e        state_q, state_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic [p-1:0]  sreg_q [n];
    logic [p-1:0]  sreg_d [n];
    logic [p-1:0]  q_load [n];
    logic [b-1:0]  shr;
    logic          out_valid, is_last, xfer, in_ready, load;

    assign shr       = bus.shr;
    assign out_valid = (state_q == st_send);
    assign is_last   = (cnt_q == '0);
    assign xfer      = out_valid & bus.out_ready;
    assign in_ready  = clr & ((state_q == st_idle) | (xfer & is_last));
    assign load      = bus.in_valid & in_ready;

    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign bus.first     = out_valid & (cnt_q == cnt_top);
    assign bus.last      = out_valid & is_last;

    for (genvar i = 0; i < int'(n); i++) begin : g_lane
        logic signed [w-1:0] t;
        assign t = $signed(bus.O[i*w +: w]) >>> shr;
        assign q_load[i] = (t > qmax) ? qmax[p-1:0] :
                           (t < qmin) ? qmin[p-1:0] : t[p-1:0];
        assign bus.D[2*i +: 2] = sreg_q[i][p-1 -: 2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            st_idle: begin
                if (load) begin
                    state_d = st_send;
                    cnt_d   = cnt_top;
                    sreg_d  = q_load;
                end
            end
            st_send: begin
                if (xfer) begin
                    if (!is_last) begin
                        cnt_d = cnt_q - cw'(1);
                        for (int i = 0; i < int'(n); i++) begin
                            sreg_d[i] = sreg_q[i] << 2;
                        end
                    end else if (load) begin
                        // back-to-back: next vector replaces the finished one with no bubble
                        cnt_d  = cnt_top;
                        sreg_d = q_load;
                    end else begin
                        // shift registers hold so D keeps its last plane while idle
                        state_d = st_idle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= st_idle;
            cnt_q   <= '0;
            for (int i = 0; i < int'(n); i++) begin
                sreg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end
endmodule
